// File: rtl/ysyx_25040109_pkg.sv
// Shared types for the two-master memory arbiter.
package ysyx_25040109_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WLEN_W = 3;
  // Wide enough for the largest legal burst limit (15).
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_IFU   = 2'd0,
    OWN_LSU_R = 2'd1,
    OWN_LSU_W = 2'd2
  } owner_e;

  // Fields held stable on the memory request port for one transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WLEN_W-1:0] wlen;
  } mem_req_t;

endpackage

// File: rtl/ysyx_25040109_prio_sel.sv
// Combinational winner select: store > load > fetch, unless fetch is starved.
module ysyx_25040109_prio_sel
  import ysyx_25040109_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_r_valid,
  input  logic   lsu_w_valid,
  input  logic   ifu_starved,
  output logic   any_valid_c,
  output owner_e winner_c
);

  // Starved fetch overrides the fixed priority order.
  always_comb begin
    any_valid_c = ifu_valid | lsu_r_valid | lsu_w_valid;
    winner_c    = OWN_IFU;
    if (ifu_valid && ifu_starved) begin
      winner_c = OWN_IFU;
    end else if (lsu_w_valid) begin
      winner_c = OWN_LSU_W;
    end else if (lsu_r_valid) begin
      winner_c = OWN_LSU_R;
    end else begin
      winner_c = OWN_IFU;
    end
  end

endmodule

// File: rtl/ysyx_25040109_mem_arbiter.sv
// Serialises IFU fetches, LSU loads and LSU stores onto one memory port.
module ysyx_25040109_mem_arbiter
  import ysyx_25040109_pkg::*;
#(
  parameter int unsigned LSU_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  output logic              imem_ready,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_rdata_valid,
  input  logic              imem_rdata_ready,
  input  logic [ADDR_W-1:0] dmem_raddr,
  input  logic              dmem_rvalid,
  output logic              dmem_rready,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_rdata_valid,
  input  logic              dmem_rdata_ready,
  input  logic [ADDR_W-1:0] dmem_waddr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [WLEN_W-1:0] dmem_wlen,
  input  logic              dmem_wvalid,
  output logic              dmem_wready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [WLEN_W-1:0] mem_req_wlen,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              mem_resp_ready,
  output logic              busy
);

  state_e             state_q;
  state_e             state_d;
  owner_e             owner_q;
  mem_req_t           req_q;
  mem_req_t           req_new_c;
  logic [CNT_W-1:0]   lsu_cnt;
  logic               ifu_starved;
  logic               any_valid_c;
  owner_e             win_c;

  assign ifu_starved = (lsu_cnt == CNT_W'(LSU_BURST_MAX));

  ysyx_25040109_prio_sel u_prio_sel (
    .ifu_valid   (imem_valid),
    .lsu_r_valid (dmem_rvalid),
    .lsu_w_valid (dmem_wvalid),
    .ifu_starved (ifu_starved),
    .any_valid_c (any_valid_c),
    .winner_c    (win_c)
  );

  // Request fields captured from the winning channel; reads carry no write payload.
  always_comb begin
    req_new_c = '0;
    case (win_c)
      OWN_LSU_W: begin
        req_new_c.we    = 1'b1;
        req_new_c.addr  = dmem_waddr;
        req_new_c.wdata = dmem_wdata;
        req_new_c.wlen  = dmem_wlen;
      end
      OWN_LSU_R: req_new_c.addr = dmem_raddr;
      default:   req_new_c.addr = imem_addr;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant bookkeeping: owner, latched request and fetch-starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_IFU;
      req_q   <= '0;
      lsu_cnt <= '0;
    end else if (state_q == ST_IDLE && any_valid_c) begin
      owner_q <= win_c;
      req_q   <= req_new_c;
      if (win_c != OWN_IFU && imem_valid) begin
        if (!ifu_starved) begin
          lsu_cnt <= CNT_W'(lsu_cnt + 1'b1);
        end
      end else begin
        lsu_cnt <= '0;
      end
    end
  end

  // Next state plus handshake outputs; readies are masked while reset is held.
  always_comb begin
    state_d          = state_q;
    imem_ready       = 1'b0;
    dmem_rready      = 1'b0;
    dmem_wready      = 1'b0;
    imem_rdata       = '0;
    imem_rdata_valid = 1'b0;
    dmem_rdata       = '0;
    dmem_rdata_valid = 1'b0;
    mem_req_valid    = 1'b0;
    mem_resp_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_c) begin
          state_d     = ST_REQ;
          imem_ready  = rst && (win_c == OWN_IFU);
          dmem_rready = rst && (win_c == OWN_LSU_R);
          dmem_wready = rst && (win_c == OWN_LSU_W);
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        case (owner_q)
          OWN_IFU: begin
            imem_rdata_valid = mem_resp_valid;
            imem_rdata       = mem_resp_rdata;
            mem_resp_ready   = imem_rdata_ready;
          end
          OWN_LSU_R: begin
            dmem_rdata_valid = mem_resp_valid;
            dmem_rdata       = mem_resp_rdata;
            mem_resp_ready   = dmem_rdata_ready;
          end
          default: mem_resp_ready = 1'b1;
        endcase
        if (mem_resp_valid && mem_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req_we    = req_q.we;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wlen  = req_q.wlen;
  assign busy          = (state_q != ST_IDLE);

endmodule
